mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W, default 32: address/data width in bits.
REQ-002 Parameter MEM_LAT, default 1, range 1..15: number of ACCESS cycles per memory transaction.
REQ-003 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive data grants tolerated while fetch waits.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  instruction-fetch read request, held with i_addr stable until i_ready.
REQ-007 i_addr  in  W  fetch byte address.
REQ-008 i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-009 i_rdata  out  W  last fetched word, held until next fetch completes.
REQ-010 d_req  in  1  data request, held with d_we/d_addr/d_wdata stable until d_ready.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  W  data byte address.
REQ-013 d_wdata  in  W  write data.
REQ-014 d_ready  out  1  one-cycle pulse: data access complete.
REQ-015 d_rdata  out  W  last data read word; unchanged by writes.
REQ-016 mem_read_en, mem_read_addr[W], mem_write_en, mem_write_addr[W], mem_write_data[W]  out  shared word-memory port.
REQ-017 mem_read_data  in  W  combinational read data from memory.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; owner register selects fetch (I) or data (D).
REQ-020 IDLE: no request -> stay IDLE; any request -> grant one requester, load latency counter with MEM_LAT-1, go ACCESS.
REQ-021 Arbitration when both requests high: grant D unless starve_cnt == STARVE_LIMIT, then grant I.
REQ-022 starve_cnt (4 bits): increments (saturating at STARVE_LIMIT) on each D grant while i_req high; clears on every I grant.
REQ-023 ACCESS: counter decrements each cycle; at zero go DONE.
REQ-024 ACCESS, owner read (I, or D with d_we=0): mem_read_en=1 every ACCESS cycle, mem_read_addr = owner address.
REQ-025 ACCESS, owner D write: mem_write_en=1 in first ACCESS cycle only, mem_write_addr=d_addr, mem_write_data=d_wdata; mem_read_en=0.
REQ-026 Read data captured from mem_read_data on the edge leaving the last ACCESS cycle into owner's rdata register.
REQ-027 DONE: owner's ready=1 for exactly this cycle; next state IDLE unconditionally; requests not sampled in DONE.
REQ-028 Latency: request high in cycle T (IDLE) -> ready high in cycle T+MEM_LAT+1; back-to-back accesses every MEM_LAT+2 cycles.
REQ-029 Requester deasserting req during ACCESS: ignored; access completes and ready still pulses.
REQ-030 Memory outputs zero when not in ACCESS; never both mem_read_en and mem_write_en high.
REQ-031 Only one transaction outstanding; the non-granted requester waits with no side effects.

Reset
REQ-032 rst low: state IDLE, owner I, counters 0, starve_cnt 0, all outputs 0 including i_rdata/d_rdata, immediately and asynchronously.
REQ-033 Reset during ACCESS aborts without ready; a write already issued is not undone.
REQ-034 First request sampled on first rising edge after rst deasserts.

Verification
REQ-035 MEM_LAT=1, i_req only, addr 0x0, mem word 0x20080005 -> mem_read_en cycle T+1, i_ready and i_rdata=0x20080005 cycle T+2.
REQ-036 d_req write d_addr 0x40, d_wdata 0xDEADBEEF, MEM_LAT=3 -> single mem_write_en pulse cycle T+1, d_ready cycle T+4, d_rdata unchanged.
REQ-037 i_req and d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 rst asserted in second ACCESS cycle of MEM_LAT=3 read -> outputs 0 at once, no ready; after release, held request completes normally.
REQ-039 i_req dropped during ACCESS -> i_ready still pulses once, FSM returns to IDLE, no further access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one word-memory port between an instruction-fetch requester and a data requester.
// Data requests normally win, but fetch is granted after STARVE_LIMIT consecutive data wins.
module mem_arbiter #(
  parameter int unsigned W            = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [W-1:0] i_addr,
  output logic         i_ready,
  output logic [W-1:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic         d_ready,
  output logic [W-1:0] d_rdata,
  output logic         mem_read_en,
  output logic [W-1:0] mem_read_addr,
  output logic         mem_write_en,
  output logic [W-1:0] mem_write_addr,
  output logic [W-1:0] mem_write_data,
  input  logic [W-1:0] mem_read_data,
  output logic         busy
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]    state, state_nxt;
  logic          owner, owner_nxt;
  logic [CW-1:0] lat_cnt, lat_cnt_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;

  logic          rd_en_nxt, wr_en_nxt;
  logic [W-1:0]  rd_addr_nxt, wr_addr_nxt, wr_data_nxt;
  logic          i_ready_nxt, d_ready_nxt;
  logic          rd_capture;

  // Memory-port outputs are registered, so they are computed for the state being entered.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    rd_en_nxt      = 1'b0;
    rd_addr_nxt    = '0;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = '0;
    wr_data_nxt    = '0;
    i_ready_nxt    = 1'b0;
    d_ready_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_req && !(i_req && (starve_cnt == CW'(STARVE_LIMIT)))) begin
          state_nxt   = S_ACCESS;
          owner_nxt   = OWN_D;
          lat_cnt_nxt = CW'(MEM_LAT - 1);
          if (i_req && (starve_cnt < CW'(STARVE_LIMIT))) begin
            starve_cnt_nxt = starve_cnt + CW'(1);
          end
          if (d_we) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = d_addr;
            wr_data_nxt = d_wdata;
          end else begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = d_addr;
          end
        end else if (i_req) begin
          state_nxt      = S_ACCESS;
          owner_nxt      = OWN_I;
          lat_cnt_nxt    = CW'(MEM_LAT - 1);
          starve_cnt_nxt = '0;
          rd_en_nxt      = 1'b1;
          rd_addr_nxt    = i_addr;
        end
      end
      S_ACCESS: begin
        if (lat_cnt == '0) begin
          state_nxt   = S_DONE;
          i_ready_nxt = (owner == OWN_I);
          d_ready_nxt = (owner == OWN_D);
        end else begin
          lat_cnt_nxt = lat_cnt - CW'(1);
          rd_en_nxt   = mem_read_en;
          rd_addr_nxt = mem_read_addr;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_capture = (state == S_ACCESS) && (lat_cnt == '0) && mem_read_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Registered outputs and the per-requester read-data holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy           <= 1'b0;
      i_ready        <= 1'b0;
      d_ready        <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
    end else begin
      busy           <= (state_nxt != S_IDLE);
      i_ready        <= i_ready_nxt;
      d_ready        <= d_ready_nxt;
      mem_read_en    <= rd_en_nxt;
      mem_read_addr  <= rd_addr_nxt;
      mem_write_en   <= wr_en_nxt;
      mem_write_addr <= wr_addr_nxt;
      mem_write_data <= wr_data_nxt;
      if (rd_capture && (owner == OWN_I)) begin
        i_rdata <= mem_read_data;
      end
      if (rd_capture && (owner == OWN_D)) begin
        d_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (grant cycle T, access T+1..T+LAT, done T+LAT+1).
module tb_mem_arbiter;

  localparam int unsigned W  = 32;
  localparam int          L  = 3;
  localparam int          SL = 4;
  localparam int unsigned NW = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic         i_ready, d_ready, busy;
  logic [W-1:0] i_rdata, d_rdata;
  logic         mem_read_en, mem_write_en;
  logic [W-1:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

  logic [W-1:0] mem     [NW];
  logic [W-1:0] ref_mem [NW];

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_addr[6:2]];

  mem_arbiter #(.W(W), .MEM_LAT(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Reference model state: at most one transaction, identified by its grant cycle.
  int           cyc = 0;
  bit           tx_act = 1'b0;
  int           tx_t = 0;
  bit           tx_own = 1'b0;
  bit           tx_we = 1'b0;
  logic [W-1:0] tx_addr = '0;
  int           starve = 0;
  logic [W-1:0] exp_irdata = '0;
  logic [W-1:0] exp_drdata = '0;
  bit           cur_done_i, cur_done_d;
  bit           obs[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mode = 0;
  int t0, seen, cnt;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] rand_addr();
    return W'($urandom_range(NW - 1, 0) * 4);
  endfunction

  // Advance the model across a rising edge using the inputs that were held before it.
  task automatic model_edge();
    bit idle_prev;
    cyc++;
    if (!rst) return;
    if (tx_act && !tx_we && (cyc == tx_t + L + 1)) begin
      if (tx_own) exp_drdata = ref_mem[tx_addr[6:2]];
      else        exp_irdata = ref_mem[tx_addr[6:2]];
    end
    idle_prev = !tx_act || ((cyc - 1) > (tx_t + L + 1));
    if (idle_prev) begin
      if (d_req && !(i_req && starve == SL)) begin
        tx_act = 1'b1; tx_t = cyc - 1; tx_own = 1'b1; tx_we = d_we; tx_addr = d_addr;
        if (i_req && starve < SL) starve++;
        if (d_we) ref_mem[d_addr[6:2]] = d_wdata;
      end else if (i_req) begin
        tx_act = 1'b1; tx_t = cyc - 1; tx_own = 1'b0; tx_we = 1'b0; tx_addr = i_addr;
        starve = 0;
      end
    end
  endtask

  task automatic check_cycle();
    int p;
    bit acc, done;
    p    = tx_act ? (cyc - tx_t) : -1;
    acc  = (p >= 1) && (p <= L);
    done = (p == L + 1);
    cur_done_i = done && !tx_own;
    cur_done_d = done && tx_own;
    check("busy",    W'(busy),    W'(acc || done));
    check("i_ready", W'(i_ready), W'(cur_done_i));
    check("d_ready", W'(d_ready), W'(cur_done_d));
    check("rd_en",   W'(mem_read_en),  W'(acc && !tx_we));
    check("wr_en",   W'(mem_write_en), W'(acc && tx_we && (p == 1)));
    if (acc && !tx_we) check("rd_addr", mem_read_addr, tx_addr);
    if (acc && tx_we && (p == 1)) begin
      check("wr_addr", mem_write_addr, tx_addr);
      check("wr_data", mem_write_data, ref_mem[tx_addr[6:2]]);
    end
    if (!acc) begin
      check("idle_rd_addr", mem_read_addr,  '0);
      check("idle_wr_addr", mem_write_addr, '0);
      check("idle_wr_data", mem_write_data, '0);
    end
    check("i_rdata", i_rdata, exp_irdata);
    check("d_rdata", d_rdata, exp_drdata);
    if (mem_write_en) mem[mem_write_addr[6:2]] = mem_write_data;
    if (i_ready) obs.push_back(1'b0);
    if (d_ready) obs.push_back(1'b1);
  endtask

  // Requester behaviour: mode 1 keeps both requests high, mode 2 issues random traffic.
  task automatic drive();
    if (mode == 1) begin
      if (cur_done_i) i_addr = rand_addr();
      if (cur_done_d) begin
        d_addr = rand_addr(); d_we = 1'($urandom_range(1, 0)); d_wdata = $urandom;
      end
    end else if (mode == 2) begin
      if (cur_done_i) i_req = 1'b0;
      if (cur_done_d) d_req = 1'b0;
      if (!i_req && ($urandom_range(3, 0) == 0)) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      if (!d_req && ($urandom_range(2, 0) == 0)) begin
        d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(1, 0)); d_wdata = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
    drive();
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < int'(NW); i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[0] = 32'h2008_0005; ref_mem[0] = 32'h2008_0005;
    mem[16] = 32'h0; ref_mem[16] = 32'h0;

    repeat (3) step();
    rst = 1'b1;

    // Fetch of word 0
    i_req = 1'b1; i_addr = '0; t0 = cyc; seen = -1;
    for (int k = 0; k < L + 4; k++) begin
      step();
      if (cyc == t0 + 1) check("fetch_rd_en_t1", W'(mem_read_en), W'(1));
      if (i_ready && seen < 0) begin
        seen = cyc;
        check("fetch_rdata", i_rdata, 32'h2008_0005);
        i_req = 1'b0;
      end
    end
    check("fetch_latency", W'(seen), W'(t0 + L + 1));

    // Data write to 0x40, then read it back
    repeat (2) step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    t0 = cyc; seen = -1; cnt = 0;
    for (int k = 0; k < L + 4; k++) begin
      step();
      if (cyc == t0 + 1) check("write_en_t1", W'(mem_write_en), W'(1));
      if (mem_write_en) cnt++;
      if (d_ready && seen < 0) begin
        seen = cyc;
        check("write_keeps_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
      end
    end
    check("write_latency", W'(seen), W'(t0 + L + 1));
    check("write_pulses", W'(cnt), W'(1));
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; seen = -1;
    for (int k = 0; k < L + 4; k++) begin
      step();
      if (d_ready && seen < 0) begin
        seen = cyc;
        check("readback", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
      end
    end
    check("readback_seen", W'(seen > 0), W'(1));

    // Both requesters held high: fetch is let in after SL data grants
    repeat (2) step();
    obs.delete();
    mode = 1; i_req = 1'b1; i_addr = rand_addr();
    d_req = 1'b1; d_we = 1'b0; d_addr = rand_addr(); d_wdata = $urandom;
    for (int k = 0; k < 10 * (L + 2) + 10 && obs.size() < 10; k++) step();
    mode = 0; i_req = 1'b0; d_req = 1'b0;
    check("grant_count", W'(obs.size()), W'(10));
    for (int k = 0; k < obs.size() && k < 10; k++)
      check($sformatf("grant_%0d", k), W'(obs[k]), W'((k % (SL + 1)) != SL));

    // Reset in the second access cycle of a fetch
    repeat (2) step();
    i_req = 1'b1; i_addr = 32'h8; t0 = cyc;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_busy",    W'(busy),        W'(0));
    check("rst_rd_en",   W'(mem_read_en), W'(0));
    check("rst_rd_addr", mem_read_addr,   '0);
    check("rst_i_ready", W'(i_ready),     W'(0));
    check("rst_i_rdata", i_rdata,         '0);
    check("rst_d_rdata", d_rdata,         '0);
    tx_act = 1'b0; starve = 0; exp_irdata = '0; exp_drdata = '0;
    step(); step();
    rst = 1'b1; t0 = cyc; seen = -1;
    for (int k = 0; k < L + 4; k++) begin
      step();
      if (i_ready && seen < 0) begin
        seen = cyc;
        check("resume_rdata", i_rdata, ref_mem[2]);
        i_req = 1'b0;
      end
    end
    check("resume_latency", W'(seen), W'(t0 + L + 1));

    // Fetch request withdrawn during its access
    repeat (2) step();
    i_req = 1'b1; i_addr = rand_addr();
    step();
    i_req = 1'b0; cnt = 0;
    for (int k = 0; k < L + 6; k++) begin
      step();
      if (i_ready) cnt++;
    end
    check("drop_ready_pulses", W'(cnt), W'(1));
    check("drop_idle", W'(busy), W'(0));

    // Random traffic
    mode = 2;
    repeat (1500) step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
